// File: rtl/reg_writeback.sv
// Register-file writeback arbiter. Each cycle it picks one result, in order:
// the single-cycle ALU/load result, the oldest buffered mul/div result, or a
// mul/div result arriving straight into an idle stage. It also keeps a
// scoreboard of destinations that are still waiting on a mul/div result.
module reg_writeback (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALU_VALID,
  input  logic [4:0]  ALU_ADDRESS,
  input  logic [31:0] ALU_DATA,
  input  logic        MD_VALID,
  input  logic [4:0]  MD_ADDRESS,
  input  logic [31:0] MD_DATA,
  output logic        MD_READY,
  input  logic        ISSUE_MD,
  input  logic [4:0]  ISSUE_ADDRESS,
  input  logic [4:0]  CHECK_ADDRESS1,
  input  logic [4:0]  CHECK_ADDRESS2,
  output logic        BUSY1,
  output logic        BUSY2,
  output logic        WB_WRITE,
  output logic [4:0]  WB_ADDRESS,
  output logic [31:0] WB_DATA
);

  // Two-entry mul/div result buffer; storage needs no reset because count
  // alone says which entries are live.
  logic [4:0]  fifo_addr [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;

  logic [31:0] scoreboard;
  logic [31:0] scoreboard_next;

  logic        wb_write;
  logic [4:0]  wb_address;
  logic [31:0] wb_data;

  logic        md_ready;
  logic        md_accept;
  logic        fifo_empty;
  logic        enq;
  logic        deq;
  logic        sel_valid;
  logic        sel_from_md;
  logic [4:0]  sel_address;
  logic [31:0] sel_data;

  // Pick this cycle's result and decide whether the FIFO pushes or pops.
  always_comb begin
    md_ready    = (count < 2'd2);
    md_accept   = MD_VALID & md_ready;
    fifo_empty  = (count == 2'd0);
    sel_valid   = 1'b0;
    sel_from_md = 1'b0;
    sel_address = ALU_ADDRESS;
    sel_data    = ALU_DATA;
    deq         = 1'b0;
    if (ALU_VALID) begin
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      sel_valid   = 1'b1;
      sel_from_md = 1'b1;
      sel_address = fifo_addr[rd_ptr];
      sel_data    = fifo_data[rd_ptr];
      deq         = 1'b1;
    end else if (md_accept) begin
      // Idle stage and empty buffer: the mul/div result skips the FIFO.
      sel_valid   = 1'b1;
      sel_from_md = 1'b1;
      sel_address = MD_ADDRESS;
      sel_data    = MD_DATA;
    end
    enq        = md_accept & (ALU_VALID | ~fifo_empty);
    count_next = count + {1'b0, enq} - {1'b0, deq};
  end

  // Scoreboard update: clear on mul/div writeback, then set on issue so a
  // same-edge set overrides the clear; x0 is never tracked.
  always_comb begin
    scoreboard_next = scoreboard;
    if (sel_valid && sel_from_md) begin
      scoreboard_next[sel_address] = 1'b0;
    end
    if (ISSUE_MD && (ISSUE_ADDRESS != 5'd0)) begin
      scoreboard_next[ISSUE_ADDRESS] = 1'b1;
    end
    scoreboard_next[0] = 1'b0;
  end

  // FIFO storage writes.
  always_ff @(posedge CLK) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= MD_ADDRESS;
      fifo_data[wr_ptr] <= MD_DATA;
    end
  end

  // FIFO pointers, occupancy and scoreboard state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      scoreboard <= 32'd0;
    end else begin
      if (deq) rd_ptr <= ~rd_ptr;
      if (enq) wr_ptr <= ~wr_ptr;
      count      <= count_next;
      scoreboard <= scoreboard_next;
    end
  end

  // Writeback register: address/data hold when nothing is selected, and a
  // result aimed at x0 updates them without raising the write enable.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wb_write   <= 1'b0;
      wb_address <= 5'd0;
      wb_data    <= 32'd0;
    end else if (sel_valid) begin
      wb_write   <= (sel_address != 5'd0);
      wb_address <= sel_address;
      wb_data    <= sel_data;
    end else begin
      wb_write <= 1'b0;
    end
  end

  // The second term covers the cycle the register file is still being written.
  assign BUSY1 = scoreboard[CHECK_ADDRESS1] | (wb_write & (wb_address == CHECK_ADDRESS1));
  assign BUSY2 = scoreboard[CHECK_ADDRESS2] | (wb_write & (wb_address == CHECK_ADDRESS2));

  assign MD_READY   = md_ready;
  assign WB_WRITE   = wb_write;
  assign WB_ADDRESS = wb_address;
  assign WB_DATA    = wb_data;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected register-file writes are queued
// as stimulus is driven and popped by a monitor whenever WB_WRITE pulses.
module tb_reg_writeback;

  logic        CLK;
  logic        RESET;
  logic        ALU_VALID;
  logic [4:0]  ALU_ADDRESS;
  logic [31:0] ALU_DATA;
  logic        MD_VALID;
  logic [4:0]  MD_ADDRESS;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic        ISSUE_MD;
  logic [4:0]  ISSUE_ADDRESS;
  logic [4:0]  CHECK_ADDRESS1;
  logic [4:0]  CHECK_ADDRESS2;
  logic        BUSY1;
  logic        BUSY2;
  logic        WB_WRITE;
  logic [4:0]  WB_ADDRESS;
  logic [31:0] WB_DATA;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_exp;
  int  n_compared;
  int  n_mismatched;

  reg_writeback dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_ADDRESS(ALU_ADDRESS), .ALU_DATA(ALU_DATA),
    .MD_VALID(MD_VALID), .MD_ADDRESS(MD_ADDRESS), .MD_DATA(MD_DATA),
    .MD_READY(MD_READY),
    .ISSUE_MD(ISSUE_MD), .ISSUE_ADDRESS(ISSUE_ADDRESS),
    .CHECK_ADDRESS1(CHECK_ADDRESS1), .CHECK_ADDRESS2(CHECK_ADDRESS2),
    .BUSY1(BUSY1), .BUSY2(BUSY2),
    .WB_WRITE(WB_WRITE), .WB_ADDRESS(WB_ADDRESS), .WB_DATA(WB_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Monitor: every write pulse must match the oldest queued expectation.
  always @(posedge CLK) begin
    #2;
    if (WB_WRITE === 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", WB_ADDRESS, WB_DATA);
      end else begin
        mon_exp = exp_q.pop_front();
        if (WB_ADDRESS !== mon_exp.addr || WB_DATA !== mon_exp.data) begin
          n_mismatched++;
          $display("FAIL wb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   WB_ADDRESS, WB_DATA, mon_exp.addr, mon_exp.data);
        end else begin
          $display("write ok: x%0d <= %h", WB_ADDRESS, WB_DATA);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_VALID = 1'b0; ALU_ADDRESS = 5'd0; ALU_DATA = 32'd0;
    MD_VALID = 1'b0; MD_ADDRESS = 5'd0; MD_DATA = 32'd0;
    ISSUE_MD = 1'b0; ISSUE_ADDRESS = 5'd0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle_inputs();
    CHECK_ADDRESS1 = 5'd0; CHECK_ADDRESS2 = 5'd0;
    repeat (2) tick();
    n_compared++;
    if (WB_WRITE !== 1'b0 || WB_ADDRESS !== 5'd0 || WB_DATA !== 32'd0) begin
      n_mismatched++;
      $display("FAIL reset_wb: got write=%b addr=%0d data=%h, required 0/0/0", WB_WRITE, WB_ADDRESS, WB_DATA);
    end
    n_compared++;
    if (MD_READY !== 1'b1 || BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_flags: got ready=%b busy1=%b busy2=%b, required 1/0/0", MD_READY, BUSY1, BUSY2);
    end
    RESET = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_alu_write();
    CHECK_ADDRESS1 = 5'd5;
    ALU_VALID = 1'b1; ALU_ADDRESS = 5'd5; ALU_DATA = 32'hDEADBEEF;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    tick();
    ALU_VALID = 1'b0;
    #1;
    n_compared++;
    if (WB_WRITE !== 1'b1 || BUSY1 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL alu_pulse: got write=%b busy1=%b, required 1/1", WB_WRITE, BUSY1);
    end
    tick();
    n_compared++;
    if (WB_WRITE !== 1'b0 || WB_ADDRESS !== 5'd5 || WB_DATA !== 32'hDEADBEEF || BUSY1 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL alu_hold: got write=%b addr=%0d data=%h busy1=%b, required 0/5/deadbeef/0",
               WB_WRITE, WB_ADDRESS, WB_DATA, BUSY1);
    end
    $display("test_alu_write done");
  endtask

  task automatic test_md_bypass();
    CHECK_ADDRESS1 = 5'd7;
    ISSUE_MD = 1'b1; ISSUE_ADDRESS = 5'd7;
    tick();
    ISSUE_MD = 1'b0;
    #1;
    n_compared++;
    if (BUSY1 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL md_busy_after_issue: got %b, required 1", BUSY1);
    end
    tick();
    MD_VALID = 1'b1; MD_ADDRESS = 5'd7; MD_DATA = 32'h12345678;
    exp_q.push_back('{addr: 5'd7, data: 32'h12345678});
    #1;
    n_compared++;
    if (MD_READY !== 1'b1 || BUSY1 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL md_offer: got ready=%b busy1=%b, required 1/1", MD_READY, BUSY1);
    end
    tick();
    MD_VALID = 1'b0;
    #1;
    n_compared++;
    if (WB_WRITE !== 1'b1 || WB_ADDRESS !== 5'd7 || BUSY1 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL md_write_cycle: got write=%b addr=%0d busy1=%b, required 1/7/1", WB_WRITE, WB_ADDRESS, BUSY1);
    end
    tick();
    n_compared++;
    if (BUSY1 !== 1'b0 || WB_WRITE !== 1'b0) begin
      n_mismatched++;
      $display("FAIL md_bit_clear: got busy1=%b write=%b, required 0/0", BUSY1, WB_WRITE);
    end
    $display("test_md_bypass done");
  endtask

  task automatic test_back_to_back();
    // cycle 0: ALU x10, MD x1 accepted and buffered
    ALU_VALID = 1'b1; ALU_ADDRESS = 5'd10; ALU_DATA = 32'hA0A0_0010;
    MD_VALID = 1'b1; MD_ADDRESS = 5'd1; MD_DATA = 32'h1111_0001;
    exp_q.push_back('{addr: 5'd10, data: 32'hA0A0_0010});
    exp_q.push_back('{addr: 5'd11, data: 32'hA0A0_0011});
    exp_q.push_back('{addr: 5'd12, data: 32'hA0A0_0012});
    exp_q.push_back('{addr: 5'd1,  data: 32'h1111_0001});
    exp_q.push_back('{addr: 5'd2,  data: 32'h2222_0002});
    exp_q.push_back('{addr: 5'd3,  data: 32'h3333_0003});
    tick();
    // cycle 1: ALU x11, MD x2 accepted, buffer now full
    ALU_ADDRESS = 5'd11; ALU_DATA = 32'hA0A0_0011;
    MD_ADDRESS = 5'd2; MD_DATA = 32'h2222_0002;
    tick();
    // cycle 2: ALU x12, MD x3 must be refused
    ALU_ADDRESS = 5'd12; ALU_DATA = 32'hA0A0_0012;
    MD_ADDRESS = 5'd3; MD_DATA = 32'h3333_0003;
    #1;
    n_compared++;
    if (MD_READY !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_full_ready: got %b, required 0", MD_READY);
    end
    tick();
    // cycle 3: ALU idle, head x1 drains, still full at cycle start
    ALU_VALID = 1'b0;
    #1;
    n_compared++;
    if (MD_READY !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_drain_ready: got %b, required 0", MD_READY);
    end
    tick();
    // cycle 4: x2 drains while x3 is accepted into the buffer
    #1;
    n_compared++;
    if (MD_READY !== 1'b1) begin
      n_mismatched++;
      $display("FAIL b2b_accept_x3: got ready=%b, required 1", MD_READY);
    end
    tick();
    MD_VALID = 1'b0;
    tick();
    tick();
    n_compared++;
    if (exp_q.size() != 0 || MD_READY !== 1'b1) begin
      n_mismatched++;
      $display("FAIL b2b_drained: got pending=%0d ready=%b, required 0/1", exp_q.size(), MD_READY);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_zero_dest();
    CHECK_ADDRESS1 = 5'd0;
    ALU_VALID = 1'b1; ALU_ADDRESS = 5'd0; ALU_DATA = 32'hFFFFFFFF;
    ISSUE_MD = 1'b1; ISSUE_ADDRESS = 5'd0;
    tick();
    ALU_VALID = 1'b0; ISSUE_MD = 1'b0;
    #1;
    n_compared++;
    if (WB_WRITE !== 1'b0 || WB_ADDRESS !== 5'd0 || WB_DATA !== 32'hFFFFFFFF) begin
      n_mismatched++;
      $display("FAIL zero_dest_wb: got write=%b addr=%0d data=%h, required 0/0/ffffffff", WB_WRITE, WB_ADDRESS, WB_DATA);
    end
    tick();
    n_compared++;
    if (BUSY1 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL zero_dest_busy: got %b, required 0", BUSY1);
    end
    $display("test_zero_dest done");
  endtask

  task automatic test_set_wins();
    CHECK_ADDRESS1 = 5'd9;
    ISSUE_MD = 1'b1; ISSUE_ADDRESS = 5'd9;
    tick();
    // x9 result bypasses and is written on the same edge x9 is re-issued
    MD_VALID = 1'b1; MD_ADDRESS = 5'd9; MD_DATA = 32'h0000_0099;
    exp_q.push_back('{addr: 5'd9, data: 32'h0000_0099});
    tick();
    MD_VALID = 1'b0; ISSUE_MD = 1'b0;
    tick();
    n_compared++;
    if (BUSY1 !== 1'b1 || WB_WRITE !== 1'b0) begin
      n_mismatched++;
      $display("FAIL set_wins: got busy1=%b write=%b, required 1/0", BUSY1, WB_WRITE);
    end
    MD_VALID = 1'b1; MD_DATA = 32'h0000_009A;
    exp_q.push_back('{addr: 5'd9, data: 32'h0000_009A});
    tick();
    MD_VALID = 1'b0;
    tick();
    n_compared++;
    if (BUSY1 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL set_wins_clear: got busy1=%b, required 0", BUSY1);
    end
    $display("test_set_wins done");
  endtask

  task automatic test_reset_midop();
    CHECK_ADDRESS1 = 5'd4; CHECK_ADDRESS2 = 5'd20;
    ISSUE_MD = 1'b1; ISSUE_ADDRESS = 5'd4;
    ALU_VALID = 1'b1; ALU_ADDRESS = 5'd14; ALU_DATA = 32'hC0DE_0014;
    MD_VALID = 1'b1; MD_ADDRESS = 5'd20; MD_DATA = 32'h2020_2020;
    exp_q.push_back('{addr: 5'd14, data: 32'hC0DE_0014});
    exp_q.push_back('{addr: 5'd15, data: 32'hC0DE_0015});
    tick();
    ISSUE_MD = 1'b0;
    ALU_ADDRESS = 5'd15; ALU_DATA = 32'hC0DE_0015;
    MD_ADDRESS = 5'd21; MD_DATA = 32'h2121_2121;
    tick();
    ALU_ADDRESS = 5'd16; ALU_DATA = 32'hC0DE_0016;
    MD_VALID = 1'b0;
    #1;
    n_compared++;
    if (BUSY1 !== 1'b1 || MD_READY !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midop_precond: got busy1=%b ready=%b, required 1/0", BUSY1, MD_READY);
    end
    #2;
    RESET = 1'b1;
    #1;
    n_compared++;
    if (WB_WRITE !== 1'b0 || WB_ADDRESS !== 5'd0 || WB_DATA !== 32'd0 ||
        MD_READY !== 1'b1 || BUSY1 !== 1'b0 || BUSY2 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midop_async: got write=%b addr=%0d data=%h ready=%b busy=%b%b, required 0/0/0/1/00",
               WB_WRITE, WB_ADDRESS, WB_DATA, MD_READY, BUSY1, BUSY2);
    end
    idle_inputs();
    tick();
    n_compared++;
    if (WB_WRITE !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midop_in_reset: got write=%b, required 0", WB_WRITE);
    end
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_compared++;
      if (WB_WRITE !== 1'b0 || MD_READY !== 1'b1 || BUSY1 !== 1'b0) begin
        n_mismatched++;
        $display("FAIL midop_after_reset[%0d]: got write=%b ready=%b busy1=%b, required 0/1/0",
                 i, WB_WRITE, MD_READY, BUSY1);
      end
    end
    $display("test_reset_midop done");
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    RESET = 1'b1;
    idle_inputs();
    CHECK_ADDRESS1 = 5'd0;
    CHECK_ADDRESS2 = 5'd0;
    test_reset();
    test_alu_write();
    test_md_bypass();
    test_back_to_back();
    test_zero_dest();
    test_set_wins();
    test_reset_midop();
    tick();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL final_queue: got %0d pending writes, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous active-high reset: CLK, RESET.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- CLK  in  1  rising-edge clock
- RESET  in  1  async active-high reset
- ALU_VALID  in  1  single-cycle ALU/load result present this cycle
- ALU_ADDRESS  in  5  destination register of ALU result
- ALU_DATA  in  32  ALU result
- MD_VALID  in  1  mul/div result offered
- MD_ADDRESS  in  5  destination register of mul/div result
- MD_DATA  in  32  mul/div result
- MD_READY  out  1  mul/div result accepted this cycle when MD_VALID=1
- ISSUE_MD  in  1  mul/div instruction issued this cycle
- ISSUE_ADDRESS  in  5  destination register of issued mul/div
- CHECK_ADDRESS1, CHECK_ADDRESS2  in  5  decode-stage source registers
- BUSY1, BUSY2  out  1  source register awaits mul/div result (combinational)
- WB_WRITE  out  1  register-file write enable
- WB_ADDRESS  out  5  register-file write address
- WB_DATA  out  32  register-file write data

Function
REQ-003 WB_WRITE, WB_ADDRESS and WB_DATA SHALL be registered; a result selected in cycle N SHALL appear on the outputs after the rising edge ending cycle N, for exactly one cycle.
REQ-004 Exactly one result SHALL be selected per cycle, priority: ALU_VALID, then FIFO head, then a direct bypass of an accepted MD result.
REQ-005 A 2-entry FIFO SHALL buffer mul/div results; MD_READY SHALL equal (count < 2).
REQ-006 An MD result SHALL be accepted on MD_VALID & MD_READY; it is enqueued unless it is bypassed (ALU_VALID=0 and FIFO empty), in which case it is selected that cycle without entering the FIFO.
REQ-007 Same-cycle dequeue and enqueue SHALL leave count unchanged and preserve FIFO order; the FIFO pointers SHALL wrap modulo 2.
REQ-008 A selected result with destination 0 SHALL be consumed but SHALL drive WB_WRITE=0; WB_ADDRESS and WB_DATA SHALL still update.
REQ-009 When no result is selected, WB_WRITE SHALL be 0 and WB_ADDRESS and WB_DATA SHALL hold their previous values.
REQ-010 The 32-bit scoreboard SHALL set bit ISSUE_ADDRESS on ISSUE_MD when ISSUE_ADDRESS is not 0; bit 0 SHALL always be 0.
REQ-011 The scoreboard bit for a mul/div result's destination SHALL clear on the edge where that result is registered onto WB_*; ALU writes SHALL NOT clear bits.
REQ-012 If a set and a clear of the same bit occur on one edge, the set SHALL win.
REQ-013 BUSYx SHALL equal scoreboard[CHECK_ADDRESSx] OR (WB_WRITE and WB_ADDRESS == CHECK_ADDRESSx); the second term covers the register-file write-to-read delay.
REQ-014 The FIFO data path SHALL be exactly 32 bits with no sign or width conversion.

Reset
REQ-015 On RESET=1, without waiting for a clock edge, the block SHALL drive WB_WRITE=0, WB_ADDRESS=0, WB_DATA=0, clear the FIFO so count=0 and MD_READY=1, and clear all scoreboard bits so BUSY1=BUSY2=0.
REQ-016 If RESET asserts during an operation, buffered results and pending scoreboard bits SHALL be discarded, and no WB_WRITE pulse SHALL occur while RESET=1.
REQ-017 On the first rising edge after RESET deasserts, the block SHALL operate normally.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ALU_VALID=1, ALU_ADDRESS=5, ALU_DATA=0xDEADBEEF -> next cycle WB_WRITE=1, WB_ADDRESS=5, WB_DATA=0xDEADBEEF, then WB_WRITE=0.
- ISSUE_MD to x7, then MD_VALID with x7=0x12345678 while ALU idle -> BUSY=1 for CHECK_ADDRESS=7 until the write, the write appears one cycle after acceptance, and bit 7 then clears.
- ALU_VALID held for 3 cycles while MD offers x1, x2, x3 -> MD_READY=0 after two accepts; after ALU stops, x1 then x2 are written in order, then x3 is accepted.
- ALU_ADDRESS=0, ALU_DATA=0xFFFFFFFF -> WB_WRITE stays 0; ISSUE_MD to x0 -> BUSY for x0 stays 0.
- ISSUE_MD x9 on the same edge that x9's earlier MD result is written -> bit 9 remains set.
- Fill the FIFO with 2 entries, scoreboard x4 set, assert RESET mid-cycle -> all outputs 0 and MD_READY=1 immediately, and no stale write follows deassertion.
